// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, programmable almost flags, overflow/underflow
// pulses and a choice of registered-read or first-word-fall-through output.
module sync_fifo #(
   parameter int unsigned pADDR_WIDTH    = 4,
   parameter int unsigned pDATA_WIDTH    = 8,
   parameter int unsigned pFWFT          = 0,
   parameter int unsigned pAFULL_THRESH  = 14,
   parameter int unsigned pAEMPTY_THRESH = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_en,
   input  logic [pDATA_WIDTH-1:0] wr_data,
   input  logic                   rd_en,
   output logic [pDATA_WIDTH-1:0] rd_data,
   output logic                   rd_valid,
   output logic                   full,
   output logic                   empty,
   output logic                   almost_full,
   output logic                   almost_empty,
   output logic [pADDR_WIDTH:0]   count,
   output logic                   overflow,
   output logic                   underflow
);

   localparam int unsigned DEPTH = 1 << pADDR_WIDTH;
   localparam int unsigned CW    = pADDR_WIDTH + 1;

   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [CW-1:0] AFULL_C  = CW'(pAFULL_THRESH);
   localparam logic [CW-1:0] AEMPTY_C = CW'(pAEMPTY_THRESH);

   logic [pDATA_WIDTH-1:0] mem [DEPTH];
   logic [CW-1:0]          wr_ptr;
   logic [CW-1:0]          rd_ptr;
   logic                   wr_acc;
   logic                   rd_acc;
   logic [CW-1:0]          count_after_rd;
   logic [CW-1:0]          count_next;

   // Accept decisions use this cycle's registered flags; the read side is resolved first
   always_comb begin
      wr_acc         = wr_en && !full;
      rd_acc         = rd_en && !empty;
      count_after_rd = count - CW'(rd_acc);
      count_next     = count_after_rd + CW'(wr_acc);
   end

   // Storage is not reset; writes are blocked while rst is high
   always_ff @(posedge clk) begin
      if (!rst && wr_acc) begin
         mem[wr_ptr[pADDR_WIDTH-1:0]] <= wr_data;
      end
   end

   // Pointers, occupancy, flags and error pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         full         <= 1'b0;
         empty        <= 1'b1;
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
      end else begin
         if (wr_acc) begin
            wr_ptr <= wr_ptr + CW'(1);
         end
         if (rd_acc) begin
            rd_ptr <= rd_ptr + CW'(1);
         end
         count        <= count_next;
         full         <= (count_next == DEPTH_C);
         empty        <= (count_next == '0);
         almost_full  <= (count_next >= AFULL_C);
         almost_empty <= (count_next <= AEMPTY_C);
         overflow     <= wr_en && full;
         underflow    <= rd_en && empty;
      end
   end

   generate
      if (pFWFT != 0) begin : g_fwft
         logic [pADDR_WIDTH-1:0] head_idx;
         logic                   bypass;

         // Head after this edge; a write into an effectively empty FIFO is forwarded directly
         always_comb begin
            head_idx = rd_ptr[pADDR_WIDTH-1:0] + pADDR_WIDTH'(rd_acc);
            bypass   = wr_acc && (count_after_rd == '0);
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               rd_data  <= '0;
               rd_valid <= 1'b0;
            end else begin
               rd_valid <= (count_next != '0);
               rd_data  <= bypass ? wr_data : mem[head_idx];
            end
         end
      end else begin : g_std
         always_ff @(posedge clk) begin
            if (rst) begin
               rd_data  <= '0;
               rd_valid <= 1'b0;
            end else begin
               rd_valid <= rd_acc;
               if (rd_acc) begin
                  rd_data <= mem[rd_ptr[pADDR_WIDTH-1:0]];
               end
            end
         end
      end
   endgenerate

   // Occupancy must always equal the pointer distance
   a_count_matches_ptrs : assert property (
      @(posedge clk) disable iff (rst) count == CW'(wr_ptr - rd_ptr)
   );

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: a standard-mode and an FWFT instance share one stimulus stream
// and are compared every cycle against a queue-based reference model.
module tb_sync_fifo;

   localparam int unsigned AW    = 4;
   localparam int unsigned DW    = 8;
   localparam int unsigned DEPTH = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          wr_en = 1'b0;
   logic          rd_en = 1'b0;
   logic [DW-1:0] wr_data = '0;

   logic [DW-1:0] s_rd_data, f_rd_data;
   logic          s_rd_valid, f_rd_valid;
   logic          s_full, f_full, s_empty, f_empty;
   logic          s_af, f_af, s_ae, f_ae;
   logic [AW:0]   s_count, f_count;
   logic          s_ovf, f_ovf, s_unf, f_unf;

   int checks   = 0;
   int failures = 0;

   logic [DW-1:0] q[$];
   logic [DW-1:0] exp_data;
   logic          exp_valid;
   logic          exp_ovf;
   logic          exp_unf;

   always #5 clk = ~clk;

   sync_fifo #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .pFWFT(0),
               .pAFULL_THRESH(14), .pAEMPTY_THRESH(2)) u_std (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
      .rd_data(s_rd_data), .rd_valid(s_rd_valid), .full(s_full), .empty(s_empty),
      .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
      .overflow(s_ovf), .underflow(s_unf)
   );

   sync_fifo #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .pFWFT(1),
               .pAFULL_THRESH(14), .pAEMPTY_THRESH(2)) u_fwft (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
      .rd_data(f_rd_data), .rd_valid(f_rd_valid), .full(f_full), .empty(f_empty),
      .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
      .overflow(f_ovf), .underflow(f_unf)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Drive one cycle of requests, advance the model, then compare both instances
   task automatic step(input logic w, input logic [DW-1:0] d, input logic r, input logic rs);
      int  n;
      logic was_full, was_empty;
      wr_en   = w;
      wr_data = d;
      rd_en   = r;
      rst     = rs;
      if (rs) begin
         q.delete();
         exp_data  = '0;
         exp_valid = 1'b0;
         exp_ovf   = 1'b0;
         exp_unf   = 1'b0;
      end else begin
         was_full  = (q.size() == DEPTH);
         was_empty = (q.size() == 0);
         exp_ovf   = w && was_full;
         exp_unf   = r && was_empty;
         exp_valid = r && !was_empty;
         if (r && !was_empty) exp_data = q.pop_front();
         if (w && !was_full) q.push_back(d);
      end
      @(posedge clk);
      @(negedge clk);
      n = q.size();
      check_eq("count",        32'(s_count),    32'(n));
      check_eq("full",         32'(s_full),     32'(n == DEPTH));
      check_eq("empty",        32'(s_empty),    32'(n == 0));
      check_eq("almost_full",  32'(s_af),       32'(n >= 14));
      check_eq("almost_empty", 32'(s_ae),       32'(n <= 2));
      check_eq("overflow",     32'(s_ovf),      32'(exp_ovf));
      check_eq("underflow",    32'(s_unf),      32'(exp_unf));
      check_eq("rd_valid",     32'(s_rd_valid), 32'(exp_valid));
      check_eq("rd_data",      32'(s_rd_data),  32'(exp_data));
      check_eq("fwft_count",   32'(f_count),    32'(n));
      check_eq("fwft_ovf",     32'(f_ovf),      32'(exp_ovf));
      check_eq("fwft_unf",     32'(f_unf),      32'(exp_unf));
      check_eq("fwft_valid",   32'(f_rd_valid), 32'(n != 0));
      if (n != 0) check_eq("fwft_data", 32'(f_rd_data), 32'(q[0]));
   endtask

   initial begin
      exp_data  = '0;
      exp_valid = 1'b0;
      exp_ovf   = 1'b0;
      exp_unf   = 1'b0;
      @(negedge clk);

      // Reset, including requests during reset that must be ignored
      step(1'b0, 8'h00, 1'b0, 1'b1);
      step(1'b1, 8'h33, 1'b1, 1'b1);

      // Fill 0x00..0x0F, then overflow with 0xAA
      for (int i = 0; i < 16; i++) step(1'b1, DW'(i), 1'b0, 1'b0);
      step(1'b1, 8'hAA, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0);

      // Drain 16 entries, then a 17th read underflows
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 8'h00, 1'b1, 1'b0);
         check_eq("drain_order", 32'(s_rd_data), 32'(i));
      end
      step(1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b0);

      // Simultaneous requests while full: read wins, write rejected
      for (int i = 0; i < 16; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
      step(1'b1, 8'hEE, 1'b1, 1'b0);
      check_eq("full_both_count", 32'(s_count), 32'd15);
      while (q.size() > 0) step(1'b0, 8'h00, 1'b1, 1'b0);

      // Simultaneous requests while empty: write wins, read rejected
      step(1'b1, 8'h77, 1'b1, 1'b0);
      check_eq("empty_both_count", 32'(s_count), 32'd1);

      // Both requests at count 5 keep the count and the order
      while (q.size() < 5) step(1'b1, 8'($urandom), 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 8'($urandom), 1'b1, 1'b0);
         check_eq("mid_both_count", 32'(s_count), 32'd5);
      end

      // Random concurrent traffic with occupancy held in 3..12 across several wraps
      while (q.size() < 8) step(1'b1, 8'($urandom), 1'b0, 1'b0);
      for (int i = 0; i < 100; i++) begin
         logic w, r;
         w = 1'($urandom_range(0, 1));
         r = 1'($urandom_range(0, 1));
         if (q.size() >= 12) w = 1'b0;
         if (q.size() <= 3)  r = 1'b0;
         step(w, 8'($urandom), r, 1'b0);
      end

      // FWFT presentation of a word written into an empty FIFO, no rd_en
      while (q.size() > 0) step(1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b1, 8'h5A, 1'b0, 1'b0);
      check_eq("fwft_5a_data",  32'(f_rd_data),  32'h5A);
      check_eq("fwft_5a_valid", 32'(f_rd_valid), 32'd1);

      // Reset mid-operation at count 7 with a read pending
      while (q.size() < 7) step(1'b1, 8'($urandom), 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b1, 8'h00, 1'b0, 1'b0);
      step(1'b1, 8'h11, 1'b1, 1'b1);
      check_eq("rst_mid_count", 32'(s_count), 32'd0);
      check_eq("rst_mid_empty", 32'(s_empty), 32'd1);
      check_eq("rst_mid_valid", 32'(f_rd_valid), 32'd0);
      step(1'b1, 8'h42, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
